// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: output widths,
// output bit positions and the legal load-use latency range.
package hazard_ctrl_pkg;

    localparam int HOLD_W       = 2;
    localparam int FLUSH_W      = 2;

    localparam int HOLD_ALL     = 1;
    localparam int HOLD_FRONT   = 0;
    localparam int FLUSH_IFID   = 1;
    localparam int FLUSH_IDEX   = 0;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;

    // Wide enough to hold LOAD_LAT_MAX-1.
    localparam int CNT_W        = 2;

endpackage

// File: rtl/hazard_ctrl_md_scoreboard.sv
// Single-entry scoreboard for one outstanding multi-cycle (mul/div) result.
// Tracks the destination register and flags ID reads that depend on it.
module md_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              set,
    input  logic              clr,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic              rs1_re,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              rs2_re,
    input  logic              md,
    output logic              valid,
    output logic              hit
);

    logic [ADDR_W-1:0] rd_q;

    // A new launch in the same cycle as a writeback wins: the old entry is
    // retired and the new destination takes its place.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            rd_q  <= '0;
        end else if (set) begin
            valid <= 1'b1;
            rd_q  <= rd;
        end else if (clr && valid) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid && ((rs1_re && (rs1 == rd_q)) ||
                           (rs2_re && (rs2 == rd_q)) ||
                           md);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall counter, bus-wait pending flag,
// optional multi-cycle scoreboard, and hold/flush generation.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MD_EN      = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  jump,
    input  logic                  busy,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic                  ID_rs1_re,
    input  logic                  ID_rs2_re,
    input  logic                  ID_md,
    input  logic [REG_ADDR_W-1:0] EX_rd,
    input  logic                  EX_rmem,
    input  logic                  EX_md_start,
    input  logic                  md_done,
    output logic [HOLD_W-1:0]     hold,
    output logic [FLUSH_W-1:0]    flush,
    output logic                  md_pending
);

    if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_load_lat
        $error("hazard_ctrl: LOAD_LAT=%0d outside %0d..%0d",
               LOAD_LAT, LOAD_LAT_MIN, LOAD_LAT_MAX);
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             ld_hit;
    logic             sb_hit;
    logic             sb_valid;
    logic             stall;

    assign ld_hit = EX_rmem && (EX_rd != '0) &&
                    ((ID_rs1_re && (ID_rs1 == EX_rd)) ||
                     (ID_rs2_re && (ID_rs2 == EX_rd)));

    assign stall = ld_hit || (cnt != '0) || pend || sb_hit;

    // The hit cycle itself is the first stall cycle, so the counter only
    // covers the remaining LOAD_LAT-1. A hit seen under busy is parked in
    // pend and turned into a counter load on the first free cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (jump) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (busy) begin
            if (ld_hit) begin
                pend <= 1'b1;
            end
        end else begin
            pend <= 1'b0;
            if (ld_hit || pend) begin
                cnt <= CNT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        hold  = '0;
        flush = '0;
        if (rstn) begin
            hold[HOLD_ALL]    = busy;
            hold[HOLD_FRONT]  = stall && !jump;
            flush[FLUSH_IFID] = jump;
            flush[FLUSH_IDEX] = stall && !jump && !busy;
        end
    end

    if (MD_EN != 0) begin : g_md
        md_scoreboard #(
            .ADDR_W (REG_ADDR_W)
        ) u_md_scoreboard (
            .clk    (clk),
            .rstn   (rstn),
            .set    (EX_md_start && !busy && (EX_rd != '0)),
            .clr    (md_done),
            .rd     (EX_rd),
            .rs1    (ID_rs1),
            .rs1_re (ID_rs1_re),
            .rs2    (ID_rs2),
            .rs2_re (ID_rs2_re),
            .md     (ID_md),
            .valid  (sb_valid),
            .hit    (sb_hit)
        );
    end else begin : g_no_md
        assign sb_valid = 1'b0;
        assign sb_hit   = 1'b0;
    end

    assign md_pending = sb_valid;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=2 and 3) share one set of
// directed inputs; a cycle-level model checks every cycle, literals pin it.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       jump, busy, rs1_re, rs2_re, id_md, ex_rmem, ex_md_start, md_done;
    logic [4:0] rs1, rs2, ex_rd;
    logic [1:0] hold2, flush2, hold3, flush3;
    logic       mdp2, mdp3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(2), .MD_EN(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .jump(jump), .busy(busy),
        .ID_rs1(rs1), .ID_rs2(rs2), .ID_rs1_re(rs1_re), .ID_rs2_re(rs2_re),
        .ID_md(id_md), .EX_rd(ex_rd), .EX_rmem(ex_rmem),
        .EX_md_start(ex_md_start), .md_done(md_done),
        .hold(hold2), .flush(flush2), .md_pending(mdp2)
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .MD_EN(1)) u_dut3 (
        .clk(clk), .rstn(rstn), .jump(jump), .busy(busy),
        .ID_rs1(rs1), .ID_rs2(rs2), .ID_rs1_re(rs1_re), .ID_rs2_re(rs2_re),
        .ID_md(id_md), .EX_rd(ex_rd), .EX_rmem(ex_rmem),
        .EX_md_start(ex_md_start), .md_done(md_done),
        .hold(hold3), .flush(flush3), .md_pending(mdp3)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic idle();
        jump = 0; busy = 0; rs1_re = 0; rs2_re = 0; id_md = 0;
        ex_rmem = 0; ex_md_start = 0; md_done = 0;
        rs1 = 0; rs2 = 0; ex_rd = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Model: stall cycles still owed after the current one, a hit parked
    // behind busy, and the single outstanding multi-cycle destination.
    int owed [2];
    bit parked [2];
    bit m_sb_v;
    int m_sb_rd;

    always @(negedge clk) begin : compare
        bit ld, sbh, st;
        logic [1:0] eh, ef, ah, af;
        int lat;
        if (!rstn) begin
            chk("rst_hold2", hold2, 2'b00);
            chk("rst_flush2", flush2, 2'b00);
            chk("rst_hold3", hold3, 2'b00);
            chk("rst_flush3", flush3, 2'b00);
            chk("rst_mdp", {mdp3, mdp2}, 2'b00);
            owed[0] = 0; owed[1] = 0; parked[0] = 0; parked[1] = 0;
            m_sb_v = 0; m_sb_rd = 0;
        end else begin
            ld  = ex_rmem && ex_rd != 0 &&
                  ((rs1_re && rs1 == ex_rd) || (rs2_re && rs2 == ex_rd));
            sbh = m_sb_v && ((rs1_re && int'(rs1) == m_sb_rd) ||
                             (rs2_re && int'(rs2) == m_sb_rd) || id_md);
            chk("model_mdp", {mdp3, mdp2}, {m_sb_v, m_sb_v});
            for (int k = 0; k < 2; k++) begin
                lat = (k == 0) ? 2 : 3;
                st  = ld || owed[k] > 0 || parked[k] || sbh;
                eh  = {busy, st && !jump};
                ef  = {jump, st && !jump && !busy};
                ah  = (k == 0) ? hold2 : hold3;
                af  = (k == 0) ? flush2 : flush3;
                chk((k == 0) ? "model_hold2" : "model_hold3", ah, eh);
                chk((k == 0) ? "model_flush2" : "model_flush3", af, ef);
                if (jump) begin
                    owed[k] = 0; parked[k] = 0;
                end else if (busy) begin
                    if (ld) parked[k] = 1;
                end else begin
                    if (ld || parked[k]) owed[k] = lat - 1;
                    else if (owed[k] > 0) owed[k] = owed[k] - 1;
                    parked[k] = 0;
                end
            end
            if (ex_md_start && !busy && ex_rd != 0) begin
                m_sb_v = 1; m_sb_rd = int'(ex_rd);
            end else if (md_done) begin
                m_sb_v = 0;
            end
        end
    end

    initial begin
        rstn = 0;
        idle();
        // Reset overrides active inputs
        jump = 1; busy = 1; ex_rmem = 1; ex_rd = 5; rs1 = 5; rs1_re = 1;
        smp();
        chk("lit_rst_hold", hold2, 2'b00);
        chk("lit_rst_flush", flush2, 2'b00);
        next(); idle(); rstn = 1;
        smp();
        chk("lit_idle_hold", hold2, 2'b00);
        chk("lit_idle_flush", flush2, 2'b00);

        // Basic load-use
        next(); ex_rmem = 1; ex_rd = 5; rs1 = 5; rs1_re = 1;
        smp(); chk("lit_ld_c0_hold", hold2, 2'b01); chk("lit_ld_c0_flush", flush2, 2'b01);
        next(); idle();
        smp(); chk("lit_ld_c1_hold", hold2, 2'b01); chk("lit_ld_c1_flush", flush2, 2'b01);
        next();
        smp(); chk("lit_ld_c2_hold", hold2, 2'b00); chk("lit_ld_c2_flush", flush2, 2'b00);
        chk("lit_ld3_c2_hold", hold3, 2'b01);
        next();
        smp(); chk("lit_ld3_c3_hold", hold3, 2'b00);

        // x0 and read-enable
        next(); ex_rmem = 1; ex_rd = 0; rs1 = 0; rs1_re = 1;
        smp(); chk("lit_x0_hold", hold2, 2'b00); chk("lit_x0_flush", flush2, 2'b00);
        next(); ex_rd = 7; rs2 = 7; rs2_re = 0;
        smp(); chk("lit_re_hold", hold2, 2'b00); chk("lit_re_flush", flush2, 2'b00);

        // Load-use under busy
        for (int i = 0; i < 3; i++) begin
            next(); idle(); busy = 1; ex_rmem = 1; ex_rd = 4; rs2 = 4; rs2_re = 1;
            smp(); chk("lit_busy_hold", hold2, 2'b11); chk("lit_busy_flush", flush2, 2'b00);
        end
        next(); busy = 0;
        smp(); chk("lit_unbusy_hold", hold2, 2'b01); chk("lit_unbusy_flush", flush2, 2'b01);
        next(); idle();
        smp(); chk("lit_unbusy_c1_hold", hold2, 2'b01);
        next();
        smp(); chk("lit_unbusy_c2_hold", hold2, 2'b00); chk("lit_unbusy3_c2_hold", hold3, 2'b01);
        next();
        smp();

        // Counter frozen under busy
        next(); ex_rmem = 1; ex_rd = 4; rs2 = 4; rs2_re = 1;
        smp();
        for (int i = 0; i < 2; i++) begin
            next(); idle(); busy = 1;
            smp(); chk("lit_frz_hold3", hold3, 2'b11);
        end
        next(); busy = 0;
        smp(); chk("lit_frz_c0_hold3", hold3, 2'b01); chk("lit_frz_c0_flush3", flush3, 2'b01);
        next();
        smp(); chk("lit_frz_c1_hold3", hold3, 2'b01);
        next();
        smp(); chk("lit_frz_c2_hold3", hold3, 2'b00);

        // Jump during stall
        next(); ex_rmem = 1; ex_rd = 5; rs1 = 5; rs1_re = 1;
        smp();
        next(); idle(); jump = 1;
        smp(); chk("lit_jmp_hold3", hold3, 2'b00); chk("lit_jmp_flush3", flush3, 2'b10);
        next(); jump = 0;
        smp(); chk("lit_jmp_nx_hold3", hold3, 2'b00); chk("lit_jmp_nx_flush3", flush3, 2'b00);

        // Scoreboard
        next(); ex_md_start = 1; ex_rd = 9;
        smp(); chk("lit_sb_set_mdp", {1'b0, mdp2}, 2'b00);
        next(); idle(); rs1 = 9; rs1_re = 1;
        smp(); chk("lit_sb_mdp", {1'b0, mdp2}, 2'b01);
        chk("lit_sb_hold", hold2, 2'b01); chk("lit_sb_flush", flush2, 2'b01);
        next();
        smp();
        next(); md_done = 1;
        smp(); chk("lit_sb_done_hold", hold2, 2'b01);
        next(); md_done = 0;
        smp(); chk("lit_sb_end_hold", hold2, 2'b00); chk("lit_sb_end_mdp", {1'b0, mdp2}, 2'b00);
        next(); md_done = 1; rs1_re = 0;
        smp();
        next(); md_done = 0; ex_md_start = 1; ex_rd = 0;
        smp();
        next(); ex_md_start = 0; id_md = 1;
        smp(); chk("lit_sb_x0_hold", hold2, 2'b00);
        next(); id_md = 0; ex_md_start = 1; ex_rd = 9;
        smp();
        next(); ex_rd = 3; md_done = 1;
        smp(); chk("lit_sb_coin_mdp", {1'b0, mdp2}, 2'b01);
        next(); idle(); rs1 = 9; rs1_re = 1;
        smp(); chk("lit_sb_coin_mdp2", {1'b0, mdp2}, 2'b01); chk("lit_sb_old9_hold", hold2, 2'b00);
        next(); rs1 = 0; rs2 = 3; rs2_re = 1;
        smp(); chk("lit_sb_new3_hold", hold2, 2'b01);
        next(); idle(); id_md = 1;
        smp(); chk("lit_sb_md_hold", hold2, 2'b01);
        next(); id_md = 0; jump = 1;
        smp(); chk("lit_sb_jmp_flush", flush2, 2'b10);
        next(); jump = 0; id_md = 1;
        smp(); chk("lit_sb_postjmp_hold", hold2, 2'b01); chk("lit_sb_postjmp_mdp", {1'b0, mdp2}, 2'b01);
        next(); idle(); md_done = 1;
        smp();
        next(); md_done = 0;
        smp(); chk("lit_sb_clr_mdp", {1'b0, mdp2}, 2'b00);
        next(); busy = 1; ex_md_start = 1; ex_rd = 8;
        smp();
        next(); idle();
        smp(); chk("lit_sb_busyset_mdp", {1'b0, mdp2}, 2'b00);

        // Async reset mid-stall
        next(); ex_rmem = 1; ex_rd = 6; rs1 = 6; rs1_re = 1; ex_md_start = 1;
        smp();
        next(); ex_rmem = 0; ex_md_start = 0; ex_rd = 0;
        #1;
        chk("lit_pre_rst_hold3", hold3, 2'b01);
        rstn = 0;
        #1;
        chk("lit_arst_hold2", hold2, 2'b00); chk("lit_arst_flush2", flush2, 2'b00);
        chk("lit_arst_hold3", hold3, 2'b00); chk("lit_arst_flush3", flush3, 2'b00);
        chk("lit_arst_mdp", {mdp3, mdp2}, 2'b00);
        smp();
        next(); idle(); rstn = 1;
        smp(); chk("lit_postrst_hold3", hold3, 2'b00); chk("lit_postrst_flush3", flush3, 2'b00);
        next();
        smp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
